// File: rtl/flash_mixer_pkg.sv
// Shared types and helpers for the flash sample mixer and related DSP blocks.
package flash_mixer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SAT   = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   // Guard bits cover the sum of n_ch full-scale samples plus one for sign headroom.
   function automatic int acc_width(input int sample_w, input int n_ch);
      return sample_w + $clog2(n_ch) + 1;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned  w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/flash_mixer_saturate.sv
// Combinational clamp of a wide accumulator to a signed sample, with clip flag.
module mix_saturate
   import flash_mixer_pkg::*;
#(
   parameter int ACC_W    = 20,
   parameter int SAMPLE_W = 16
) (
   input  logic signed [ACC_W-1:0]    acc,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       clip
);

   logic signed [63:0] wide;
   logic signed [63:0] clamped;

   assign wide    = 64'(acc);
   assign clamped = saturate(wide, SAMPLE_W);
   assign sample  = clamped[SAMPLE_W-1:0];
   assign clip    = (clamped != wide);

endmodule

// File: rtl/flash_mixer.sv
// N-channel mixer: per frame fetches one sample per active channel, attenuates, sums and saturates.
module flash_mixer
   import flash_mixer_pkg::*;
#(
   parameter int N_CH     = 5,
   parameter int ADDR_W   = 21,
   parameter int SAMPLE_W = 16,
   parameter int DATA_LSB = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_frame,
   input  logic [N_CH-1:0]          i_ch_enb,
   input  logic [N_CH-1:0]          i_ch_loop,
   input  logic [N_CH-1:0]          i_ch_trig,
   input  logic [3*N_CH-1:0]        i_ch_shift,
   input  logic [ADDR_W*N_CH-1:0]   i_base,
   input  logic [ADDR_W*N_CH-1:0]   i_len,
   output logic                     o_rd_stb,
   output logic [ADDR_W-1:0]        o_rd_addr,
   input  logic                     i_rd_ack,
   input  logic [31:0]              i_rd_data,
   output logic [SAMPLE_W-1:0]      o_sample,
   output logic                     o_sample_vld,
   output logic                     o_clip,
   output logic                     o_overrun,
   output logic [N_CH-1:0]          o_ch_active,
   output logic                     o_busy
);

   localparam int ACC_W = acc_width(SAMPLE_W, N_CH);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t                      state;
   logic [CH_W-1:0]             ch;
   logic signed [ACC_W-1:0]     acc;
   logic [ADDR_W-1:0]           ptr [N_CH];
   logic [N_CH-1:0]             pending;
   logic [SAMPLE_W-1:0]         sat_q;
   logic                        clip_q;

   logic [ADDR_W-1:0]           base_arr  [N_CH];
   logic [ADDR_W-1:0]           len_arr   [N_CH];
   logic [2:0]                  shift_arr [N_CH];

   logic signed [SAMPLE_W-1:0]  rd_sample;
   logic signed [ACC_W-1:0]     rd_ext;
   logic signed [ACC_W-1:0]     rd_term;
   logic signed [SAMPLE_W-1:0]  sat_val;
   logic                        sat_clip;
   logic                        last_ch;
   logic                        fetch_go;
   logic [N_CH-1:0]             trig_eff;
   logic                        unused_rd;

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         base_arr[i]  = i_base[i*ADDR_W +: ADDR_W];
         len_arr[i]   = i_len[i*ADDR_W +: ADDR_W];
         shift_arr[i] = i_ch_shift[i*3 +: 3];
      end
   end

   assign rd_sample = i_rd_data[DATA_LSB +: SAMPLE_W];
   assign rd_ext    = ACC_W'(rd_sample);
   assign rd_term   = rd_ext >>> shift_arr[ch];
   assign unused_rd = ^i_rd_data;

   assign last_ch   = (ch == CH_W'(N_CH - 1));
   assign fetch_go  = i_ch_enb[ch] & o_ch_active[ch];
   // A trigger arriving in the SAT cycle itself is honoured rather than deferred a frame.
   assign trig_eff  = pending | i_ch_trig;
   assign o_busy    = (state != ST_IDLE);

   mix_saturate #(
      .ACC_W    (ACC_W),
      .SAMPLE_W (SAMPLE_W)
   ) u_sat (
      .acc    (acc),
      .sample (sat_val),
      .clip   (sat_clip)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         ch           <= '0;
         acc          <= '0;
         o_rd_stb     <= 1'b0;
         o_rd_addr    <= '0;
         pending      <= '0;
         o_ch_active  <= '1;
         sat_q        <= '0;
         clip_q       <= 1'b0;
         o_sample     <= '0;
         o_sample_vld <= 1'b0;
         o_clip       <= 1'b0;
         o_overrun    <= 1'b0;
         for (int unsigned i = 0; i < N_CH; i++)
            ptr[i] <= '0;
      end else begin
         pending      <= pending | i_ch_trig;
         o_sample_vld <= 1'b0;
         o_clip       <= 1'b0;
         o_overrun    <= i_frame & o_busy;

         case (state)
            ST_IDLE: begin
               if (i_frame) begin
                  acc   <= '0;
                  ch    <= '0;
                  state <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               if (fetch_go) begin
                  o_rd_stb  <= 1'b1;
                  o_rd_addr <= base_arr[ch] + ptr[ch];
                  state     <= ST_WAIT;
               end else if (last_ch) begin
                  state <= ST_SAT;
               end else begin
                  ch <= ch + 1'b1;
               end
            end

            ST_WAIT: begin
               if (i_rd_ack) begin
                  o_rd_stb <= 1'b0;
                  acc      <= acc + rd_term;
                  if (last_ch) begin
                     state <= ST_SAT;
                  end else begin
                     ch    <= ch + 1'b1;
                     state <= ST_FETCH;
                  end
               end
            end

            ST_SAT: begin
               sat_q   <= sat_val;
               clip_q  <= sat_clip;
               pending <= '0;
               for (int unsigned i = 0; i < N_CH; i++) begin
                  if (trig_eff[i]) begin
                     ptr[i]         <= '0;
                     o_ch_active[i] <= 1'b1;
                  end else if (o_ch_active[i]) begin
                     if (ptr[i] == len_arr[i] - ADDR_W'(1)) begin
                        ptr[i] <= '0;
                        if (!i_ch_loop[i])
                           o_ch_active[i] <= 1'b0;
                     end else begin
                        ptr[i] <= ptr[i] + ADDR_W'(1);
                     end
                  end else begin
                     ptr[i] <= '0;
                  end
               end
               state <= ST_OUT;
            end

            ST_OUT: begin
               o_sample     <= sat_q;
               o_sample_vld <= 1'b1;
               o_clip       <= clip_q;
               state        <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_mixer.sv
// Self-checking bench for flash_mixer: vector table, corner sequences and randomized frames vs a reference model.
module tb_flash_mixer;

   localparam int N  = 5;
   localparam int AW = 21;
   localparam int SW = 16;
   localparam int DL = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame;
   logic [N-1:0]      ch_enb, ch_loop, ch_trig, ch_active;
   logic [3*N-1:0]    ch_shift;
   logic [AW*N-1:0]   base, len;
   logic              rd_stb, rd_ack;
   logic [AW-1:0]     rd_addr;
   logic [31:0]       rd_data;
   logic [SW-1:0]     sample;
   logic              sample_vld, clip, overrun, busy;

   always #5 clk = ~clk;

   flash_mixer #(
      .N_CH     (N),
      .ADDR_W   (AW),
      .SAMPLE_W (SW),
      .DATA_LSB (DL)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_frame      (frame),
      .i_ch_enb     (ch_enb),
      .i_ch_loop    (ch_loop),
      .i_ch_trig    (ch_trig),
      .i_ch_shift   (ch_shift),
      .i_base       (base),
      .i_len        (len),
      .o_rd_stb     (rd_stb),
      .o_rd_addr    (rd_addr),
      .i_rd_ack     (rd_ack),
      .i_rd_data    (rd_data),
      .o_sample     (sample),
      .o_sample_vld (sample_vld),
      .o_clip       (clip),
      .o_overrun    (overrun),
      .o_ch_active  (ch_active),
      .o_busy       (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Flash model configuration and read log
   int            lat_fix  = 3;
   bit            lat_rand = 1'b0;
   bit            use_fixed = 1'b1;
   logic [15:0]   chval [N];
   logic [AW-1:0] addr_log [$];

   int            cfg_base [N];
   int            cfg_len  [N];

   function automatic logic [15:0] sample_at(input logic [AW-1:0] a);
      logic [31:0] h;
      if (use_fixed)
         return chval[int'(a >> 8)];
      h = (32'(a) * 32'd40503) ^ (32'(a) << 5) ^ 32'h9E37;
      return h[15:0];
   endfunction

   initial begin
      int cnt;
      int want;
      cnt = 0;
      want = 1;
      rd_ack = 1'b0;
      rd_data = '0;
      forever begin
         @(negedge clk);
         if (rd_ack) begin
            rd_ack = 1'b0;
            cnt = 0;
         end else if (rd_stb === 1'b1 && rst === 1'b0) begin
            if (cnt == 0)
               want = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
            cnt++;
            if (cnt >= want) begin
               rd_ack  = 1'b1;
               rd_data = {8'hA5, sample_at(rd_addr), 8'h3C};
               addr_log.push_back(rd_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Reference model: pointers, activity and pending triggers
   int            m_ptr [N];
   logic [N-1:0]  m_act;
   logic [N-1:0]  m_pend;
   logic [AW-1:0] exp_addr [$];

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_ptr[i] = 0;
      m_act  = '1;
      m_pend = '0;
   endtask

   task automatic model_frame(output logic [15:0] es, output logic ec);
      longint acc;
      int v;
      acc = 0;
      exp_addr.delete();
      for (int i = 0; i < N; i++) begin
         if (m_act[i] && ch_enb[i]) begin
            logic [AW-1:0] a;
            a = AW'(cfg_base[i] + m_ptr[i]);
            exp_addr.push_back(a);
            v = int'($signed(sample_at(a)));
            v = v >>> int'(ch_shift[3*i +: 3]);
            acc += v;
         end
      end
      if (acc > 32767) begin
         es = 16'h7FFF; ec = 1'b1;
      end else if (acc < -32768) begin
         es = 16'h8000; ec = 1'b1;
      end else begin
         es = 16'(acc); ec = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (m_pend[i]) begin
            m_ptr[i] = 0;
            m_act[i] = 1'b1;
         end else if (m_act[i]) begin
            m_ptr[i] = (m_ptr[i] + 1) % cfg_len[i];
            if (m_ptr[i] == 0 && !ch_loop[i]) m_act[i] = 1'b0;
         end
      end
      m_pend = '0;
   endtask

   task automatic apply_cfg();
      for (int i = 0; i < N; i++) begin
         base[i*AW +: AW] = AW'(cfg_base[i]);
         len[i*AW +: AW]  = AW'(cfg_len[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      frame = 1'b0;
      ch_trig = '0;
      apply_cfg();
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_trig(input logic [N-1:0] mask);
      @(negedge clk);
      ch_trig = mask;
      @(negedge clk);
      ch_trig = '0;
      m_pend |= mask;
   endtask

   task automatic run_frame(output logic [15:0] s, output logic c, output int cycles);
      int n;
      bit got;
      addr_log.delete();
      s = 'x; c = 1'bx;
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      n = 1;
      got = 1'b0;
      while (!got && n < 400) begin
         if (sample_vld === 1'b1) begin
            got = 1'b1;
            s = sample;
            c = clip;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      cycles = n;
      if (!got) check("vld_timeout", 64'(n), 64'(0));
   endtask

   task automatic check_frame(input string tag, input bit chk_time, input bit cmp_sample,
                              output logic [15:0] gs, output logic gc);
      logic [15:0] es;
      logic        ec;
      int          cyc;
      int          nr;
      model_frame(es, ec);
      run_frame(gs, gc, cyc);
      if (cmp_sample) begin
         check({tag, "_sample"}, 64'(gs), 64'(es));
         check({tag, "_clip"},   64'(gc), 64'(ec));
      end
      check({tag, "_nreads"}, 64'(addr_log.size()), 64'(exp_addr.size()));
      nr = (addr_log.size() < exp_addr.size()) ? addr_log.size() : exp_addr.size();
      for (int k = 0; k < nr; k++)
         check($sformatf("%s_addr%0d", tag, k), 64'(addr_log[k]), 64'(exp_addr[k]));
      check({tag, "_active"}, 64'(ch_active), 64'(m_act));
      if (chk_time)
         check({tag, "_latency"}, 64'(cyc), 64'(N + 3 + exp_addr.size() * lat_fix));
   endtask

   function automatic int ch1_addr();
      int r;
      r = -1;
      foreach (addr_log[k])
         if (addr_log[k] >= 256 && addr_log[k] < 512) r = int'(addr_log[k]);
      return r;
   endfunction

   typedef struct {
      logic [N-1:0]   enb;
      logic [3*N-1:0] shift;
      logic [15:0]    v [N];
      logic [15:0]    exp_s;
      logic           exp_c;
      int             exp_reads;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [15:0] gs;
      logic        gc;
      int          k;
      int          offs [5];

      tbl[0] = '{enb:5'b11111, shift:15'h0, v:'{16'h1000,16'h1000,16'h1000,16'h1000,16'h1000}, exp_s:16'h5000, exp_c:1'b0, exp_reads:5};
      tbl[1] = '{enb:5'b11111, shift:15'h0, v:'{16'h7000,16'h7000,16'h7000,16'h7000,16'h7000}, exp_s:16'h7FFF, exp_c:1'b1, exp_reads:5};
      tbl[2] = '{enb:5'b11111, shift:15'h0, v:'{16'h9000,16'h9000,16'h9000,16'h9000,16'h9000}, exp_s:16'h8000, exp_c:1'b1, exp_reads:5};
      tbl[3] = '{enb:5'b00001, shift:15'h2, v:'{16'h4000,16'h7000,16'h7000,16'h7000,16'h7000}, exp_s:16'h1000, exp_c:1'b0, exp_reads:1};
      tbl[4] = '{enb:5'b00000, shift:15'h0, v:'{16'h1234,16'h1234,16'h1234,16'h1234,16'h1234}, exp_s:16'h0000, exp_c:1'b0, exp_reads:0};
      tbl[5] = '{enb:5'b00011, shift:15'h0, v:'{16'h7FFF,16'h0001,16'h0000,16'h0000,16'h0000}, exp_s:16'h7FFF, exp_c:1'b1, exp_reads:2};
      tbl[6] = '{enb:5'b00001, shift:15'h7, v:'{16'h8000,16'h0000,16'h0000,16'h0000,16'h0000}, exp_s:16'hFF00, exp_c:1'b0, exp_reads:1};
      tbl[7] = '{enb:5'b00011, shift:15'h0, v:'{16'h7000,16'h0FFF,16'h0000,16'h0000,16'h0000}, exp_s:16'h7FFF, exp_c:1'b0, exp_reads:2};
      tbl[8] = '{enb:5'b00001, shift:15'h0, v:'{16'h8000,16'h0000,16'h0000,16'h0000,16'h0000}, exp_s:16'h8000, exp_c:1'b0, exp_reads:1};

      for (int i = 0; i < N; i++) begin
         cfg_base[i] = i * 256;
         cfg_len[i]  = 8;
      end
      ch_enb = '1; ch_loop = '1; ch_shift = '0; ch_trig = '0; frame = 1'b0;
      base = '0; len = '0;
      do_reset();

      check("rst_stb",     64'(rd_stb),     64'(0));
      check("rst_addr",    64'(rd_addr),    64'(0));
      check("rst_sample",  64'(sample),     64'(0));
      check("rst_vld",     64'(sample_vld), 64'(0));
      check("rst_clip",    64'(clip),       64'(0));
      check("rst_overrun", 64'(overrun),    64'(0));
      check("rst_busy",    64'(busy),       64'(0));
      check("rst_active",  64'(ch_active),  64'(5'b11111));

      // Vector table: fixed per-channel samples, fixed 3-cycle ack
      use_fixed = 1'b1; lat_rand = 1'b0; lat_fix = 3;
      for (int t = 0; t < 9; t++) begin
         ch_enb = tbl[t].enb;
         ch_shift = tbl[t].shift;
         for (int i = 0; i < N; i++) chval[i] = tbl[t].v[i];
         check_frame($sformatf("vec%0d", t), 1'b1, 1'b0, gs, gc);
         check($sformatf("vec%0d_tsample", t), 64'(gs), 64'(tbl[t].exp_s));
         check($sformatf("vec%0d_tclip", t),   64'(gc), 64'(tbl[t].exp_c));
         check($sformatf("vec%0d_treads", t),  64'(addr_log.size()), 64'(tbl[t].exp_reads));
      end

      // One-shot channel 1 with len 4, then retrigger
      use_fixed = 1'b0;
      cfg_len[1] = 4;
      ch_enb = '1; ch_loop = 5'b11101; ch_shift = {5{3'd3}};
      do_reset();
      for (int f = 0; f < 4; f++)
         check_frame($sformatf("os%0d", f), 1'b1, 1'b1, gs, gc);
      check("os_inactive", 64'(ch_active[1]), 64'(0));
      check_frame("os4", 1'b1, 1'b1, gs, gc);
      check("os_no_ch1_read", 64'(ch1_addr()), 64'(-1));
      pulse_trig(5'b00010);
      check_frame("os5", 1'b1, 1'b1, gs, gc);
      check("os_retrig_active", 64'(ch_active[1]), 64'(1));
      check_frame("os6", 1'b1, 1'b1, gs, gc);
      check("os_retrig_addr", 64'(ch1_addr()), 64'(256));

      // Loop mode channel 1 with len 4: offsets 0,1,2,3,0
      ch_loop = '1;
      do_reset();
      offs = '{0, 1, 2, 3, 0};
      for (int f = 0; f < 5; f++) begin
         check_frame($sformatf("lp%0d", f), 1'b1, 1'b1, gs, gc);
         check($sformatf("lp%0d_ch1addr", f), 64'(ch1_addr()), 64'(256 + offs[f]));
      end

      // Frame re-pulsed while waiting on a read
      begin
         logic [15:0] es;
         logic        ec;
         int          nvld;
         model_frame(es, ec);
         addr_log.delete();
         @(negedge clk); frame = 1'b1;
         @(negedge clk); frame = 1'b0;
         k = 0;
         while (rd_stb !== 1'b1 && k < 50) begin @(negedge clk); k++; end
         check("ovr_stb_seen", 64'(rd_stb), 64'(1));
         frame = 1'b1;
         @(negedge clk); frame = 1'b0;
         check("ovr_pulse", 64'(overrun), 64'(1));
         @(negedge clk);
         check("ovr_pulse_end", 64'(overrun), 64'(0));
         nvld = 0; gs = 'x;
         for (int c = 0; c < 80; c++) begin
            if (sample_vld === 1'b1) begin nvld++; gs = sample; end
            @(negedge clk);
         end
         check("ovr_single_vld", 64'(nvld), 64'(1));
         check("ovr_sample", 64'(gs), 64'(es));
         check("ovr_nreads", 64'(addr_log.size()), 64'(exp_addr.size()));
      end

      // Reset asserted while a read is outstanding
      check_frame("pre_rst", 1'b1, 1'b1, gs, gc);
      @(negedge clk); frame = 1'b1;
      @(negedge clk); frame = 1'b0;
      k = 0;
      while (rd_stb !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("mr_stb_seen", 64'(rd_stb), 64'(1));
      rst = 1'b1;
      #1;
      check("mr_stb_drop", 64'(rd_stb),    64'(0));
      check("mr_sample",   64'(sample),    64'(0));
      check("mr_active",   64'(ch_active), 64'(5'b11111));
      check("mr_busy",     64'(busy),      64'(0));
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_frame("post_rst", 1'b1, 1'b1, gs, gc);
      check("post_rst_addr0", 64'(addr_log.size() > 0 ? addr_log[0] : '1), 64'(0));

      // Randomized frames with random lengths, modes, attenuation, triggers and ack latency
      for (int i = 0; i < N; i++) cfg_len[i] = int'($urandom_range(1, 6));
      cfg_len[2] = 1;
      lat_rand = 1'b1;
      do_reset();
      for (int f = 0; f < 40; f++) begin
         ch_enb   = N'($urandom);
         ch_loop  = N'($urandom);
         ch_shift = (3*N)'($urandom);
         if ($urandom_range(0, 3) == 0) pulse_trig(N'($urandom));
         check_frame($sformatf("rnd%0d", f), 1'b0, 1'b1, gs, gc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
